// File: rtl/reg_bank.sv
// Purpose : multi-ported register file with per-register pending (scoreboard) marks.
// Latency : reads are combinational (0 cycles) with write-to-read bypass; writes land on the rising edge.
// Backpressure: none; every write, issue and flush is accepted on the cycle it is presented.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   wr_en/addr/data     write port; a write also clears the pending mark of its target
//   iss_en/iss_addr     marks a destination register pending
//   flush               clears every pending mark (a same-cycle issue still lands)
//   rd_addr/rd_data     NREAD packed read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rd_busy             per-port pending flag, un-busied by a same-cycle completing write
//   busy_vec            registered pending vector, no bypass
module reg_bank #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    // Register 0 is read-only when hardwired; flag it once for reuse.
    logic wr_to_zero;
    logic iss_to_zero;
    assign wr_to_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign iss_to_zero = (ZERO_REG != 0) && (iss_addr == '0);

    // Effective write: gated by reset so an in-flight write is invisible on the
    // bypass path while rst_n is low, keeping all outputs at zero in reset.
    logic wr_hit;
    logic wr_live;
    assign wr_live = wr_en && rst_n;
    assign wr_hit  = wr_live && !wr_to_zero;

    // ---------------------------------------------------------------
    // Data storage
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // ---------------------------------------------------------------
    // Pending vector. Ordering matters: flush first, then the write
    // clears its mark, then the issue sets its mark, so an issue wins
    // over both a flush and a same-register completing write.
    // ---------------------------------------------------------------
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end
        if (wr_en) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (iss_en && !iss_to_zero) begin
            pending_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy_vec = pending;

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          wr_match;

        assign addr     = rd_addr[p*AW +: AW];
        assign is_zero  = (ZERO_REG != 0) && (addr == '0);
        assign wr_match = wr_live && (wr_addr == addr);

        // wr_hit already excludes register 0, so is_zero and the bypass
        // never conflict; is_zero is checked first for clarity.
        assign rd_data[p*XLEN +: XLEN] = is_zero                  ? '0      :
                                         (wr_hit && wr_match)     ? wr_data :
                                                                    regs[addr];

        // pending[0] is never set when hardwired, so no zero special case.
        assign rd_busy[p] = pending[addr] && !wr_match;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count; power of two, >= 2; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2: number of read ports, >= 1.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 hardwires register 0 to zero.
REQ-005 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: wr_en  in  1  write strobe.
REQ-008 SHALL have ports: wr_addr  in  AW  write register index.
REQ-009 SHALL have ports: wr_data  in  XLEN  write data.
REQ-010 SHALL have ports: iss_en  in  1  mark destination pending.
REQ-011 SHALL have ports: iss_addr  in  AW  register to mark pending.
REQ-012 SHALL have ports: flush  in  1  clear all pending marks.
REQ-013 SHALL have ports: rd_addr  in  NREAD*AW  read indices; port i at bits [i*AW +: AW].
REQ-014 SHALL have ports: rd_data  out  NREAD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
REQ-015 SHALL have ports: rd_busy  out  NREAD  port i register pending.
REQ-016 SHALL have ports: busy_vec  out  NREGS  pending mark of every register.

Function
REQ-017 SHALL hold NREGS x XLEN storage plus an NREGS-bit pending vector.
REQ-018 SHALL combinationally read all ports in parallel, with no read latency.
REQ-019 SHALL write wr_data into wr_addr on the rising edge when wr_en=1, unless ZERO_REG=1 and wr_addr=0.
REQ-020 SHALL bypass writes to reads: when wr_en=1 and rd_addr[i]=wr_addr (write not suppressed), rd_data[i]=wr_data in the same cycle.
REQ-021 SHALL, with ZERO_REG=1, read register 0 as 0 on every port, and never report register 0 busy.
REQ-022 SHALL on the edge set pending[iss_addr] when iss_en=1; an issue to register 0 is ignored when ZERO_REG=1.
REQ-023 SHALL on the edge clear pending[wr_addr] when wr_en=1.
REQ-024 SHALL, when iss_en and wr_en target the same register in the same cycle, store the data AND leave pending set (issue wins).
REQ-025 SHALL have rd_busy[i]=pending[rd_addr[i]] AND NOT (wr_en AND wr_addr=rd_addr[i]): a completing write un-busies combinationally.
REQ-026 SHALL on the edge, when flush=1, clear all pending bits; a simultaneous iss_en still sets its bit (issue after flush); data writes proceed normally.
REQ-027 SHALL, when multiple read ports address the same register, return identical data/busy on each.
REQ-028 SHALL drive busy_vec = registered pending vector (no bypass).

Reset
REQ-029 SHALL, while rst_n=0, clear every register to 0 and every pending bit to 0 immediately, independent of clk.
REQ-030 SHALL ignore wr_en, iss_en and flush while rst_n=0; a write in flight at assertion is lost.
REQ-031 SHALL resume normal operation on the first rising edge after rst_n deasserts; all outputs read 0 until then.

Verification
REQ-032 SHALL cover: reset, then read all registers on every port -> rd_data=0, rd_busy=0, busy_vec=0.
REQ-033 SHALL cover: write x5=0xDEADBEEF with rd_addr[0]=5 the same cycle -> rd_data[0]=0xDEADBEEF before and after edge.
REQ-034 SHALL cover: write x0=0x1234 and issue x0 (ZERO_REG=1) -> x0 reads 0, busy_vec[0]=0.
REQ-035 SHALL cover: issue x7; next cycle read x7 -> rd_busy=1; then wr_en x7=0x55 -> rd_busy=0 in that cycle and busy_vec[7]=0 after edge.
REQ-036 SHALL cover: issue x3 and write x3=0xA same cycle -> x3 reads 0xA, busy_vec[3]=1; then flush with iss x4 -> busy_vec has only bit 4 set.
REQ-037 SHALL cover: pulse rst_n low mid-cycle after writes to x1..x31 -> all data and busy clear asynchronously; first post-reset write lands correctly.
